// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, width default and counter sizing for the serial adder
package serial_add_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder from two half adders and an OR on the carries
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic S,
  output logic C
);
  logic w_s0, w_c0, w_c1;
  Half_Adder u_ha0 (.a(x),    .b(y),  .S(w_s0), .C(w_c0));
  Half_Adder u_ha1 (.a(w_s0), .b(ci), .S(S),    .C(w_c1));
  assign C = w_c0 | w_c1;
endmodule

// File: rtl/half_adder.sv
// Half_Adder: 1-bit half adder, the building block of the adder cells
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic S,
  output logic C
);
  assign S = a ^ b;
  assign C = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder stepping one shared full adder cell LSB-first.
// Define SERIAL_ADD_SUB_EN to add the i_sub port (A-B via ~B and carry-in 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  localparam int CW = clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout;
  logic             w_s, w_c, w_last, w_load, w_sub;
`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = i_sub;
`else
  assign w_sub = 1'b0;
`endif
  full_adder_cell u_cell (.x(r_a[0]), .y(r_b[0]), .ci(r_carry), .S(w_s), .C(w_c));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_load = (r_state == IDLE) && i_start;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (i_start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  // sum bits enter at the MSB so SUM is aligned after exactly WIDTH steps
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= i_a;
      r_b     <= w_sub ? ~i_b : i_b;
      r_carry <= w_sub;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_cout <= w_c;
    end
  assign o_busy = r_state != IDLE;
  assign o_done = r_state == DONE;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic         clk = 0, rst_n = 0, start = 0, sub = 0;
  logic [W-1:0] a = 0, b = 0, sum;
  logic         busy, done, cout;
  int           checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub(sub),
`endif
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one operation from an IDLE cycle; inj>=0 pulses a stray START at that RUN sample
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub, input int inj, input string tag);
    longint unsigned t;
    int done_n, dcnt, bcnt;
    logic [W-1:0] s_at, e_sum;
    logic c_at, e_cout;
    t = longint'(ta) + (tsub ? longint'(~tb) : longint'(tb)) + longint'(tsub);
    e_sum = W'(t);
    e_cout = t[W];
    done_n = -1; dcnt = 0; bcnt = 0; s_at = '0; c_at = 1'b0;
    a = ta; b = tb; sub = tsub; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int n = 0; n < W + 4; n++) begin
      if (n == inj) begin start = 1; a = '1; b = '1; end
      else if (inj >= 0 && n == inj + 1) start = 0;
      bcnt += int'(busy);
      if (done) begin dcnt++; done_n = n; s_at = sum; c_at = cout; end
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, done_n, W);
    check({tag, "_ndone"}, dcnt, 1);
    check({tag, "_busy"}, bcnt, W + 1);
    check({tag, "_sum"}, s_at, e_sum);
    check({tag, "_cout"}, c_at, e_cout);
    check({tag, "_hold"}, sum, e_sum);
  endtask
  initial begin
    int prev, npulse, dcnt;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    op(8'h5A, 8'h3C, 0, -1, "basic");
    op(8'hFF, 8'h01, 0, -1, "wrap");
    op(8'h00, 8'h00, 0, -1, "zero");
    op(8'h12, 8'h34, 0, 3, "ignore_start");
    op(8'hF0, 8'h20, 0, -1, "carry_set");
    a = 8'h55; b = 8'h66; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1;
    dcnt = 0;
    for (int n = 0; n < W + 4; n++) begin
      @(posedge clk); #1;
      dcnt += int'(done);
    end
    check("abort_nodone", dcnt, 0);
    op(8'h80, 8'h80, 0, -1, "after_abort");
    a = 8'h01; b = 8'h01; start = 1;
    prev = -1; npulse = 0;
    for (int n = 0; n < 4 * (W + 2); n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (prev < 0) check("held_first", n, W);
        else check("held_period", n - prev, W + 2);
        check("held_sum", sum, 8'h02);
        prev = n; npulse++;
      end
    end
    check("held_pulses", npulse, 4);
    start = 0;
    repeat (W + 3) @(posedge clk);
    #1;
`ifdef SERIAL_ADD_SUB_EN
    op(8'h10, 8'h01, 1, -1, "sub_pos");
    op(8'h01, 8'h02, 1, -1, "sub_neg");
`endif
    for (int i = 0; i < 12; i++) begin
      logic rs;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      op(W'($urandom), W'($urandom), rs, -1, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
